// File: rtl/tt_pll_pkg.sv
// Shared PLL types and constants used by the loop-filter scan controller.
package tt_pll_pkg;

    localparam int LPF_ACC_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } scan_state_t;

    typedef enum logic {
        SCAN_READ  = 1'b0,
        SCAN_WRITE = 1'b1
    } scan_op_e;

endpackage

// File: rtl/tt_lpf_scan_ctrl_if.sv
// Command/response bundle between the register block and the scan controller.
interface tt_lpf_scan_ctrl_if #(
    parameter int SCAN_LEN = tt_pll_pkg::LPF_ACC_W
);
    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic                i_cmd_write;
    logic [SCAN_LEN-1:0] i_cmd_wdata;
    logic                o_busy;
    logic                o_done;
    logic [SCAN_LEN-1:0] o_rdata;

    modport master (
        output i_cmd_valid, i_cmd_write, i_cmd_wdata,
        input  o_cmd_ready, o_busy, o_done, o_rdata
    );

    modport slave (
        input  i_cmd_valid, i_cmd_write, i_cmd_wdata,
        output o_cmd_ready, o_busy, o_done, o_rdata
    );
endinterface

// File: rtl/tt_lpf_scan_ctrl_shreg.sv
// Generic left-shifting register with parallel load and serial input.
// The parallel output is an MSB-aligned window of OUT_W bits.
module tt_scan_shreg #(
    parameter int W     = 32,
    parameter int OUT_W = 32
) (
    input  logic             i_clk_gen,
    input  logic             i_rst,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [OUT_W-1:0] q_out
);
    logic [W-1:0] q;

    always_ff @(posedge i_clk_gen) begin
        if (i_rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[W-2:0], ser_in};
        end
    end

    assign q_out = q[W-1 -: OUT_W];
endmodule

// File: rtl/tt_lpf_scan_ctrl.sv
// Turns one read/write command into a single full rotation of the loop
// filter's scan chain, capturing the pre-pass accumulator on the way.
module tt_lpf_scan_ctrl
    import tt_pll_pkg::*;
#(
    parameter int SCAN_LEN = LPF_ACC_W
) (
    input  logic              i_clk_gen,
    input  logic              i_rst,
    tt_lpf_scan_ctrl_if.slave cmd,
    output logic              o_scan_en,
    output logic              o_scan_in,
    input  logic              i_scan_out
);
    localparam int               CNT_W    = $clog2(SCAN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_LEN - 1);

    scan_state_t         state;
    scan_op_e            op;
    logic [CNT_W-1:0]    cnt;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                accept;
    logic                tx_msb;
    logic [SCAN_LEN-1:0] cap_q;

    assign accept = (state == IDLE) && cmd.i_cmd_valid;

    always_ff @(posedge i_clk_gen) begin
        if (i_rst) begin
            state   <= IDLE;
            op      <= SCAN_READ;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state   <= SHIFT;
                        op      <= scan_op_e'(cmd.i_cmd_write);
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Terminal count is compared, so the counter never wraps.
                    if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    tt_scan_shreg #(.W(SCAN_LEN), .OUT_W(1)) u_tx (
        .i_clk_gen (i_clk_gen),
        .i_rst     (i_rst),
        .load      (accept),
        .load_data (cmd.i_cmd_wdata),
        .shift_en  (busy_q),
        .ser_in    (1'b0),
        .q_out     (tx_msb)
    );

    // Capture is never loaded: it only fills during SHIFT, so it holds the
    // last pass's result until the next pass starts overwriting it.
    tt_scan_shreg #(.W(SCAN_LEN), .OUT_W(SCAN_LEN)) u_cap (
        .i_clk_gen (i_clk_gen),
        .i_rst     (i_rst),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (busy_q),
        .ser_in    (i_scan_out),
        .q_out     (cap_q)
    );

    // Reads feed scan-out straight back so the chain rotates unchanged.
    assign o_scan_en       = busy_q;
    assign o_scan_in       = busy_q & ((op == SCAN_WRITE) ? tx_msb : i_scan_out);
    assign cmd.o_cmd_ready = ready_q;
    assign cmd.o_busy      = busy_q;
    assign cmd.o_done      = done_q;
    assign cmd.o_rdata     = cap_q;
endmodule

// File: tb/tb_tt_lpf_scan_ctrl.sv
// Directed bench: scan controller driving a behavioural 32-bit loop-filter
// accumulator (scan chain plus +/-4 integration when not scanning).
module tb_tt_lpf_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en, scan_in, scan_out;
    logic        flt_rst, up, down;
    logic [31:0] acc;
    int          n_assert = 0;
    int          n_fail   = 0;

    tt_lpf_scan_ctrl_if #(.SCAN_LEN(32)) bus ();

    tt_lpf_scan_ctrl #(.SCAN_LEN(32)) dut (
        .i_clk_gen  (clk),
        .i_rst      (rst),
        .cmd        (bus),
        .o_scan_en  (scan_en),
        .o_scan_in  (scan_in),
        .i_scan_out (scan_out)
    );

    always #5 clk = ~clk;

    // Loop filter: frozen while scanning, otherwise integrates by 4.
    always_ff @(posedge clk) begin
        if (flt_rst)      acc <= '0;
        else if (scan_en) acc <= {acc[30:0], scan_in};
        else              acc <= acc + (down ? 32'd4 : 32'd0) - (up ? 32'd4 : 32'd0);
    end
    assign scan_out = acc[31];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one command, checks pass timing, returns rdata and the
    // accumulator in the done cycle. down_during is applied after accept.
    task automatic run_cmd(input string tag, input logic wr, input logic [31:0] wd,
                           input logic down_during,
                           output logic [31:0] rd, output logic [31:0] acc_done);
        int en_cnt;
        int done_cyc;
        rd       = 'x;
        acc_done = 'x;
        chk({tag, "_ready"}, 32'(bus.o_cmd_ready), 32'd1);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = wr;
        bus.i_cmd_wdata = wd;
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_write = ~wr;
        bus.i_cmd_wdata = ~wd;
        down            = down_during;
        en_cnt   = 0;
        done_cyc = -1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            if (scan_en) en_cnt++;
            if (bus.o_done) begin
                done_cyc = c;
                rd       = bus.o_rdata;
                acc_done = acc;
            end else begin
                tick();
            end
        end
        chk_int({tag, "_en_cycles"}, en_cnt, 32);
        chk_int({tag, "_done_cycle"}, done_cyc, 33);
        tick();
        chk({tag, "_ready_again"}, 32'(bus.o_cmd_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd, ad;
        int acc_cyc[8];
        int n_acc, n_done, n_viol, waited;

        rst = 1'b1; flt_rst = 1'b1; up = 1'b0; down = 1'b0;
        bus.i_cmd_valid = 1'b0; bus.i_cmd_write = 1'b0; bus.i_cmd_wdata = '0;
        tick();
        tick();
        chk("rst_ready",   32'(bus.o_cmd_ready), 32'd1);
        chk("rst_busy",    32'(bus.o_busy),      32'd0);
        chk("rst_done",    32'(bus.o_done),      32'd0);
        chk("rst_scan_en", 32'(scan_en),         32'd0);
        chk("rst_scan_in", 32'(scan_in),         32'd0);
        chk("rst_rdata",   bus.o_rdata,          32'd0);
        rst = 1'b0; flt_rst = 1'b0;
        tick();

        // Write then two non-destructive reads
        run_cmd("wr_dead", 1'b1, 32'hDEADBEEF, 1'b0, rd, ad);
        chk("wr_dead_old", rd, 32'h0);
        chk("wr_dead_acc", acc, 32'hDEADBEEF);
        run_cmd("rd1", 1'b0, 32'h0, 1'b0, rd, ad);
        chk("rd1_data", rd, 32'hDEADBEEF);
        run_cmd("rd2", 1'b0, 32'h0, 1'b0, rd, ad);
        chk("rd2_data", rd, 32'hDEADBEEF);
        chk("rd2_acc", acc, 32'hDEADBEEF);

        // Swap semantics
        run_cmd("pre5", 1'b1, 32'h5, 1'b0, rd, ad);
        run_cmd("swap", 1'b1, 32'h12345678, 1'b0, rd, ad);
        chk("swap_old", rd, 32'h5);
        run_cmd("swap_rd", 1'b0, 32'h0, 1'b0, rd, ad);
        chk("swap_rd_data", rd, 32'h12345678);

        // Integration frozen during the pass, resumes afterwards
        run_cmd("pre10", 1'b1, 32'h10, 1'b0, rd, ad);
        run_cmd("frz", 1'b0, 32'h0, 1'b1, rd, ad);
        chk("frz_rdata", rd, 32'h10);
        chk("frz_acc_done", ad, 32'h10);
        chk("frz_acc_p1", acc, 32'h14);
        tick();
        chk("frz_acc_p2", acc, 32'h18);
        down = 1'b0;

        // Continuous valid: accepts 34 cycles apart, never while busy
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = 1'b0;
        n_acc = 0; n_done = 0; n_viol = 0;
        for (int c = 0; c < 106; c++) begin
            if (bus.o_cmd_ready) begin
                if (n_acc < 8) acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (bus.o_cmd_ready && bus.o_busy) n_viol++;
            if (bus.o_done) n_done++;
            tick();
        end
        bus.i_cmd_valid = 1'b0;
        chk_int("b2b_accepts", n_acc, 4);
        chk_int("b2b_gap0", acc_cyc[1] - acc_cyc[0], 34);
        chk_int("b2b_gap2", acc_cyc[3] - acc_cyc[2], 34);
        chk_int("b2b_dones", n_done, 3);
        chk_int("b2b_overlap", n_viol, 0);
        waited = 0;
        while (!bus.o_cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk("b2b_drain_ready", 32'(bus.o_cmd_ready), 32'd1);
        chk("b2b_acc", acc, 32'h18);

        // Reset in shift cycle 10
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = 1'b1;
        bus.i_cmd_wdata = 32'hAAAAAAAA;
        tick();
        bus.i_cmd_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        chk("mid_scan_en_c10", 32'(scan_en), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_scan_en", 32'(scan_en),         32'd0);
        chk("mid_ready",   32'(bus.o_cmd_ready), 32'd1);
        chk("mid_done",    32'(bus.o_done),      32'd0);
        chk("mid_rdata",   bus.o_rdata,          32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.o_done) n_done++;
            tick();
        end
        chk_int("mid_no_done", n_done, 0);

        // Boundary values, sign bit preserved
        flt_rst = 1'b1;
        tick();
        flt_rst = 1'b0;
        run_cmd("wr_msb", 1'b1, 32'h80000000, 1'b0, rd, ad);
        chk("wr_msb_old", rd, 32'h0);
        run_cmd("rd_msb", 1'b0, 32'h0, 1'b0, rd, ad);
        chk("rd_msb_data", rd, 32'h80000000);
        chk_int("rd_msb_signed", int'($signed(acc)), -2147483647 - 1);
        run_cmd("wr_ones", 1'b1, 32'hFFFFFFFF, 1'b0, rd, ad);
        chk("wr_ones_old", rd, 32'h80000000);
        run_cmd("rd_ones", 1'b0, 32'h0, 1'b0, rd, ad);
        chk("rd_ones_data", rd, 32'hFFFFFFFF);
        chk_int("rd_ones_signed", int'($signed(acc)), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/tt_lpf_scan_ctrl.md
# tt_lpf_scan_ctrl

Scan sequencer for the loop-filter integrator. It converts a single-word read or write command into exactly one full pass of the filter's serial scan chain, driving scan-enable and scan-in and capturing scan-out. Firmware and test logic can therefore read or preload the 32-bit phase accumulator without hand-toggling the chain. It sits between the control/register interface and the loop filter's `i_scan_en` / `i_scan_in` / `o_scan_out` pins, on the same `i_clk_gen` domain.

## Interface
- `SCAN_LEN`, 32: scan-chain length in bits; must equal the integrator width.
- `i_clk_gen`  in  1: generated clock, shared with the loop filter.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_cmd_valid`  in  1: command request.
- `o_cmd_ready`  out  1: controller can accept a command.
- `i_cmd_write`  in  1: 0 = read (non-destructive), 1 = write (load `i_cmd_wdata`).
- `i_cmd_wdata`  in  SCAN_LEN: value to load on a write.
- `o_busy`  out  1: a scan pass is in progress.
- `o_done`  out  1: one-cycle pulse when a pass completes.
- `o_rdata`  out  SCAN_LEN: accumulator value captured before the pass; valid while `o_done` is high and held until the next accept.
- `o_scan_en`  out  1: to the filter's `i_scan_en`.
- `o_scan_in`  out  1: to the filter's `i_scan_in`.
- `i_scan_out`  in  1: from the filter's `o_scan_out` (accumulator MSB).

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
  - IDLE → SHIFT on `i_cmd_valid && o_cmd_ready`.
  - SHIFT → DONE when the bit counter reaches SCAN_LEN-1.
  - DONE → IDLE unconditionally.
- **Ready:** `o_cmd_ready` = (state == IDLE). `o_busy` = (state == SHIFT).
- **On accept:**
  - Latch `i_cmd_write` into an op register.
  - Latch `i_cmd_wdata` into a transmit shift register.
  - Clear the bit counter, which is $clog2(SCAN_LEN) bits wide.
- **During SHIFT:**
  - `o_scan_en` = 1.
  - Write op: `o_scan_in` = transmit MSB; transmit register shifts left each cycle. The word is therefore sent MSB first and lands in the accumulator in the same bit order.
  - Read op: `o_scan_in` = `i_scan_out`, combinational. The chain rotates, so after SCAN_LEN shifts the accumulator holds its original value.
  - Every SHIFT edge: capture register <= {capture[SCAN_LEN-2:0], `i_scan_out`}. After SCAN_LEN edges it equals the pre-pass accumulator.
- **Outside SHIFT:** `o_scan_en` = 0 and `o_scan_in` = 0.
- **In DONE:** `o_done` = 1 and `o_rdata` = capture register.
- **Write returns old value:** a write also returns the old accumulator value in `o_rdata` (swap semantics).
- **Frozen loop:** while `o_scan_en` is high the filter does not integrate. The loop is frozen for exactly SCAN_LEN cycles per command.

## Timing
- **Reset values:** state IDLE, `o_cmd_ready` 1, `o_busy` 0, `o_done` 0, `o_scan_en` 0, `o_scan_in` 0, `o_rdata` 0, counter 0.
- **Cycle-level sequence:**
  - Accept edge = cycle 0.
  - `o_scan_en` is high for cycles 1..SCAN_LEN, exactly SCAN_LEN clocks.
  - `o_done` is high in cycle SCAN_LEN+1.
  - `o_cmd_ready` is high again in cycle SCAN_LEN+2.
  - Command-to-command minimum spacing is SCAN_LEN+2 cycles.
- **Ignored inputs:** `i_cmd_valid` while not ready is ignored (no queueing). `i_cmd_wdata` / `i_cmd_write` may change freely after accept.
- **Reset mid-pass:**
  - The next edge forces IDLE and `o_scan_en` = 0.
  - No `o_done` pulse.
  - The accumulator is left partially shifted, and that is accepted.
  - The filter's own async reset is independent and clears the accumulator regardless.
- **Counter rollover:** the counter never wraps mid-pass. The terminal count is compared, not overflowed.

## Structure
- **Shared package `tt_pll_pkg`:**
  - `scan_state_t` enum (IDLE, SHIFT, DONE).
  - `scan_op_e` (SCAN_READ = 0, SCAN_WRITE = 1).
  - `LPF_ACC_W` = 32 constant, used as the SCAN_LEN default.
- **Sub-module `tt_scan_shreg`:** a generic SCAN_LEN shift register with load, shift-enable and serial-in. Instantiate it twice, once for transmit and once for capture. The FSM and counter stay in the top.

## Test plan
- **Write then read:** write 0xDEADBEEF to a filter with `i_up` = `i_down` = 0 → `o_scan_en` high exactly 32 cycles. Then read → `o_rdata` = 0xDEADBEEF, and a second read also returns 0xDEADBEEF (non-destructive).
- **Swap:** preload 0x00000005, write 0x12345678 → `o_rdata` = 0x00000005, and a subsequent read returns 0x12345678.
- **Integration freeze:** hold `i_down` = 1 during a read of 0x00000010 → accumulator is 0x00000010 after the pass and integrates only after `o_scan_en` falls (+4 per cycle).
- **Back-to-back valid:** keep `i_cmd_valid` asserted continuously → accepts spaced exactly 34 cycles apart; one `o_done` per accept; no accept while busy.
- **Reset mid-pass:** assert `i_rst` in shift cycle 10 → next cycle `o_scan_en` = 0, `o_cmd_ready` = 1, no `o_done`, `o_rdata` = 0.
- **Boundary values:** write 0x80000000 and 0xFFFFFFFF, then read each back → exact match; sign bit preserved on `o_filtered_control_signal` (-2147483648 and -1).
